dram_be_pipe: RTL and testbench
===============================

DRAM_BE_PIPE -- requirements
Module: dram_be_pipe

Interface
REQ-001 Parameters: DATA_W, default 16, word width in bits, multiple of 8, >= 8.
REQ-002 Parameters: NUM_DATA, default 512, depth in words, >= 2.
REQ-003 Parameters: RD_LAT, default 2, read latency in cycles, legal range 1..4.
REQ-004 Parameters: LANES = DATA_W/8, derived, not overridable.
REQ-005 Clocking: one clock, clk. Reset is rst, synchronous, active-high.
REQ-006 Port list (name, direction, width, meaning):
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous active-high reset
- clr  in  1  pulse, start memory-clear sequence
- we  in  1  write enable
- waddr  in  29  write word index
- wdata  in  DATA_W  write data
- wbe  in  LANES  byte-lane write enables, bit i covers wdata[8i+7:8i]
- re  in  1  read request
- raddr  in  29  read word index
- rdata  out  DATA_W  read data, registered
- rvalid  out  1  one-cycle pulse, rdata valid
- busy  out  1  clear sequence in progress

Function
REQ-007 The FSM SHALL have two states: IDLE and CLEAR.
REQ-008 CLEAR SHALL write all-zero words to indices 0..NUM_DATA-1, one word per cycle, in ascending order.
REQ-009 The CLEAR -> IDLE transition SHALL occur on the cycle after index NUM_DATA-1 is written; a clear takes exactly NUM_DATA cycles.
REQ-010 busy SHALL be 1 exactly while in CLEAR.
REQ-011 clr sampled high in IDLE SHALL enter CLEAR next cycle; any we/re in the same cycle SHALL be dropped.
REQ-012 clr sampled high in CLEAR SHALL be ignored; there is no restart.
REQ-013 we and re SHALL be ignored in CLEAR.
REQ-014 Writes: in IDLE, with we=1 and waddr<NUM_DATA, each lane with wbe[i]=1 SHALL update at the posedge; lanes with wbe[i]=0 SHALL be retained.
REQ-015 Writes with waddr>=NUM_DATA SHALL be dropped with no side effect.
REQ-016 Reads: in IDLE, with re=1, rvalid SHALL pulse exactly RD_LAT cycles later carrying that word; a fully pipelined read SHALL be accepted every cycle.
REQ-017 A read with raddr>=NUM_DATA SHALL still produce an rvalid pulse, with rdata=0.
REQ-018 Same-cycle read and write to the same in-range index SHALL be write-first per lane: enabled lanes return wdata, other lanes return old contents.
REQ-019 A read issued the cycle after a write to the same index SHALL return the written value.
REQ-020 rdata SHALL hold its last value while rvalid=0.
REQ-021 Reads accepted before a clr SHALL complete normally, with pre-clear data; pipeline order SHALL be preserved.
REQ-022 Index arithmetic: the full 29-bit compare against NUM_DATA SHALL be used, with no truncation or wrap-around of out-of-range indices.

Reset
REQ-023 rst=1 SHALL set rdata=0 and rvalid=0, flush the read pipeline, and load the clear counter with 0.
REQ-024 On rst release the block SHALL enter CLEAR with busy=1.
REQ-025 rst asserted mid-clear or mid-read SHALL restart the clear from index 0 and discard in-flight reads.
REQ-026 rst SHALL take priority over clr, we and re.

Verification (DATA_W=16, NUM_DATA=512, RD_LAT=2)
REQ-027 Release rst, then count cycles -> busy=1 for exactly 512 cycles, then 0; a subsequent read of any index 0..511 returns 0x0000.
REQ-028 Write idx 5 = 0xABCD with wbe=2'b11, then write idx 5 = 0x1200 with wbe=2'b10, then read 5 -> rvalid two cycles later, rdata=0x12CD.
REQ-029 With idx 7 = 0x0000, in the same cycle write idx 7 = 0x55AA (wbe=2'b01) and read 7 -> rdata=0x00AA; back-to-back reads of 0,1,2 -> three consecutive rvalid pulses returning their data in order.
REQ-030 Read idx 600 and write idx 600 -> rvalid pulses with rdata=0x0000; memory is unchanged.
REQ-031 Issue a read of idx 3 (=0x1111), then clr on the next cycle -> rdata=0x1111 arrives; busy=1 for 512 cycles; a second clr mid-clear has no effect; a read of 3 afterward returns 0.
REQ-032 Assert rst at clear index 200 -> busy stays 1, and the clear lasts a full 512 cycles after release.

Source files
------------

// File: rtl/dram_be_pipe.sv
// dram_be_pipe -- byte-enabled word memory with a pipelined read port and a
// self-running clear sequencer.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr           pulse: start zeroing every word (ignored while already clearing)
//   we/waddr/wdata/wbe   write port, wbe[i] enables byte lane i
//   re/raddr      read request; rdata/rvalid return RD_LAT cycles later
//   rdata, rvalid registered read result and one-cycle valid pulse
//   busy          high while the clear sequence owns the memory
//
// Reset drops the block into CLEAR with the counter at 0, so memory contents
// are always zero after reset release plus NUM_DATA cycles.

// One byte lane of storage. The write is visible to a read of the same
// address in the same cycle (write-first), per lane.
module dram_be_lane #(
  parameter int NUM_DATA = 512,
  parameter int AW       = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [NUM_DATA];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

module dram_be_pipe #(
  parameter  int DATA_W   = 16,
  parameter  int NUM_DATA = 512,
  parameter  int RD_LAT   = 2,
  localparam int LANES    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [28:0]       waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  wbe,
  input  logic              re,
  input  logic [28:0]       raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);
  localparam int            AW    = $clog2(NUM_DATA);
  localparam logic [28:0]   DEPTH = 29'(NUM_DATA);
  localparam logic [AW-1:0] LAST  = AW'(NUM_DATA - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  logic                        acc, w_in, r_in, wr_fire, rd_fire, clearing;
  logic [AW-1:0]               lane_addr;
  logic [LANES-1:0][7:0]       lane_rd;
  logic [DATA_W-1:0]           rd_word;
  logic [RD_LAT:1]             vld_pipe;
  logic [RD_LAT:1][DATA_W-1:0] dat_pipe;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (clr) begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
      CLEAR: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy = (state == CLEAR);

  // ---------------- request qualification ----------------
  // A clr pulse in IDLE swallows any same-cycle we/re. Range checks use the
  // full 29-bit index so large indices never alias onto real words.
  assign acc      = (state == IDLE) && !clr && !rst;
  assign w_in     = waddr < DEPTH;
  assign r_in     = raddr < DEPTH;
  assign wr_fire  = acc && we && w_in;
  assign rd_fire  = acc && re;
  assign clearing = (state == CLEAR) && !rst;
  assign lane_addr = clearing ? cnt : waddr[AW-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dram_be_lane #(.NUM_DATA(NUM_DATA), .AW(AW)) u_lane (
      .clk   (clk),
      .we    (clearing || (wr_fire && wbe[i])),
      .waddr (lane_addr),
      .wdata (clearing ? 8'h00 : wdata[8*i +: 8]),
      .raddr (raddr[AW-1:0]),
      .rdata (lane_rd[i])
    );
  end

  // Out-of-range reads still flow down the pipe, carrying zero.
  assign rd_word = r_in ? lane_rd : '0;

  // ---------------- read pipeline ----------------
  // Data stages only load behind a valid, so the last stage (rdata) holds
  // its value across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_fire;
      if (rd_fire) dat_pipe[1] <= rd_word;
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign rdata  = dat_pipe[RD_LAT];
  assign rvalid = vld_pipe[RD_LAT];
endmodule

// File: tb/tb_dram_be_pipe.sv
// Bench for dram_be_pipe (DATA_W=16, NUM_DATA=512, RD_LAT=2). Reads push an
// expected word and arrival cycle onto a queue; a negedge monitor pops and
// compares every rvalid pulse and checks rdata holds between pulses.
module tb_dram_be_pipe;
  localparam int DATA_W = 16, NUM_DATA = 512, RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [28:0]       waddr = '0, raddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [1:0]        wbe = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid, busy;

  dram_be_pipe #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .wbe(wbe), .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] d; int due; } exp_t;
  exp_t        q[$];
  logic [15:0] model [NUM_DATA];
  int          n_cmp = 0, n_err = 0;

  // Scoreboard monitor
  initial begin
    logic [15:0] last;
    bit          rst_d;
    exp_t        e;
    last  = '0;
    rst_d = 1'b1;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rvalid_unexpected: got pulse rdata=%h at cycle %0d, required no pulse", rdata, cyc);
        end else begin
          e = q.pop_front();
          if (rdata !== e.d || cyc !== e.due) begin
            n_err++;
            $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d", rdata, cyc, e.d, e.due);
          end
        end
      end else if (!rst && !rst_d) begin
        n_cmp++;
        if (rdata !== last) begin
          n_err++;
          $display("FAIL rdata_hold: got %h with rvalid=0, required %h", rdata, last);
        end
      end
      last  = rdata;
      rst_d = rst;
    end
  end

  task automatic drive(input logic c, input logic w, input logic [28:0] wa,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic r, input logic [28:0] ra, input bit acc);
    exp_t e;
    @(posedge clk); #1;
    clr = c; we = w; waddr = wa; wdata = wd; wbe = be; re = r; raddr = ra;
    if (acc && r) begin
      e.d = (ra < 29'd512) ? model[ra[8:0]] : 16'h0000;
      if (w && wa == ra && ra < 29'd512)
        for (int l = 0; l < 2; l++) if (be[l]) e.d[l*8 +: 8] = wd[l*8 +: 8];
      e.due = cyc + RD_LAT;
      q.push_back(e);
    end
    if (acc && w && wa < 29'd512)
      for (int l = 0; l < 2; l++) if (be[l]) model[wa[8:0]][l*8 +: 8] = wd[l*8 +: 8];
  endtask

  task automatic wr(input logic [28:0] a, input logic [15:0] d, input logic [1:0] be);
    drive(1'b0, 1'b1, a, d, be, 1'b0, 29'd0, 1'b1);
  endtask

  task automatic rd(input logic [28:0] a);
    drive(1'b0, 1'b0, 29'd0, 16'h0, 2'b00, 1'b1, a, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 29'd0, 16'h0, 2'b00, 1'b0, 29'd0, 1'b1);
  endtask

  task automatic drain(input string name);
    idle();
    repeat (RD_LAT + 2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_rvalid: got %0d reads outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < NUM_DATA; i++) model[i] = 16'h0000;
  endtask

  task automatic measure_busy(output int n);
    int t;
    n = 0; t = 0;
    @(negedge clk);
    while (!busy && t < 20) begin @(negedge clk); t++; end
    while (busy && n < 2000) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 3;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b, required 0", rvalid); end
    if (rdata !== 16'h0) begin n_err++; $display("FAIL reset_rdata: got %h, required 0000", rdata); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b, required 1", busy); end
    @(posedge clk); #1; rst = 1'b0;
    measure_busy(n);
    n_cmp++;
    if (n != 512) begin n_err++; $display("FAIL reset_clear_len: got %0d busy cycles, required 512", n); end
    zero_model();
    for (int i = 0; i < NUM_DATA; i++) rd(29'(i));
    drain("reset_readback");
  endtask

  task automatic test_byte_en();
    wr(29'd5, 16'hABCD, 2'b11);
    wr(29'd5, 16'h1200, 2'b10);
    rd(29'd5);
    drain("byte_en");
    n_cmp++;
    if (rdata !== 16'h12CD) begin n_err++; $display("FAIL byte_en: got %h, required 12CD", rdata); end
  endtask

  task automatic test_back_to_back();
    // same-cycle write+read, write-first per lane
    drive(1'b0, 1'b1, 29'd7, 16'h55AA, 2'b01, 1'b1, 29'd7, 1'b1);
    drain("fwd");
    n_cmp++;
    if (rdata !== 16'h00AA) begin n_err++; $display("FAIL same_cycle_fwd: got %h, required 00AA", rdata); end
    wr(29'd0, 16'h0A0A, 2'b11);
    wr(29'd1, 16'h1B1B, 2'b11);
    wr(29'd2, 16'h2C2C, 2'b11);
    rd(29'd0); rd(29'd1); rd(29'd2);
    wr(29'd9, 16'hBEEF, 2'b11);
    rd(29'd9);
    drain("back_to_back");
    n_cmp++;
    if (rdata !== 16'hBEEF) begin n_err++; $display("FAIL read_after_write: got %h, required BEEF", rdata); end
  endtask

  task automatic test_out_of_range();
    wr(29'd511, 16'h7777, 2'b11);
    wr(29'd600, 16'hFFFF, 2'b11);
    wr(29'd512, 16'hEEEE, 2'b11);
    wr(29'h1FFF_FFFF, 16'hDDDD, 2'b11);
    wr(29'h1000_0005, 16'hCCCC, 2'b11);
    rd(29'd600); rd(29'd512); rd(29'h1FFF_FFFF);
    rd(29'd88); rd(29'd0); rd(29'd5); rd(29'd511);
    drive(1'b0, 1'b1, 29'd600, 16'h4321, 2'b11, 1'b1, 29'd600, 1'b1);
    drain("out_of_range");
    n_cmp++;
    if (rdata !== 16'h0000) begin n_err++; $display("FAIL oor_rdata: got %h, required 0000", rdata); end
  endtask

  task automatic test_clr();
    int n;
    wr(29'd3, 16'h1111, 2'b11);
    rd(29'd3);
    drive(1'b1, 1'b0, 29'd0, 16'h0, 2'b00, 1'b0, 29'd0, 1'b0);
    idle();
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      n++;
      if (n == 100) begin
        clr = 1'b1; we = 1'b1; waddr = 29'd3; wdata = 16'hFFFF; wbe = 2'b11; re = 1'b1; raddr = 29'd3;
      end else begin
        clr = 1'b0; we = 1'b0; re = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp += 2;
    if (n != 512) begin n_err++; $display("FAIL clr_len: got %0d busy cycles, required 512", n); end
    if (rdata !== 16'h1111) begin n_err++; $display("FAIL clr_preclear_read: got %h, required 1111", rdata); end
    zero_model();
    rd(29'd3); rd(29'd0); rd(29'd511);
    drain("clr");
    n_cmp++;
    if (rdata !== 16'h0000) begin n_err++; $display("FAIL clr_result: got %h, required 0000", rdata); end
  endtask

  task automatic test_rst_midclear();
    int n;
    // reset while a read is in flight: the read is discarded
    wr(29'd20, 16'h2020, 2'b11);
    rd(29'd20);
    @(posedge clk); #1; rst = 1'b1; re = 1'b0; we = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    measure_busy(n);
    n_cmp++;
    if (n != 512) begin n_err++; $display("FAIL rst_midread_len: got %0d busy cycles, required 512", n); end
    zero_model();
    // reset at clear index ~200, with clr/we/re also asserted
    wr(29'd10, 16'hAAAA, 2'b11);
    drive(1'b1, 1'b0, 29'd0, 16'h0, 2'b00, 1'b0, 29'd0, 1'b0);
    idle();
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    rst = 1'b1; clr = 1'b1; we = 1'b1; waddr = 29'd10; wdata = 16'h1234; wbe = 2'b11; re = 1'b1; raddr = 29'd10;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b, required 1", busy); end
      @(posedge clk);
    end
    #1; rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
    measure_busy(n);
    n_cmp++;
    if (n != 512) begin n_err++; $display("FAIL rst_midclear_len: got %0d busy cycles, required 512", n); end
    zero_model();
    rd(29'd10); rd(29'd200); rd(29'd511);
    drain("rst_midclear");
  endtask

  initial begin
    test_reset();
    test_byte_en();
    test_back_to_back();
    test_out_of_range();
    test_clr();
    test_rst_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
